fp_mult_pipe: RTL and testbench
===============================

Name: fp_mult_pipe

Overview:
- Parametrised, pipelined floating-point multiplier; next generation of the combinational single-precision multiplier.
- Generalised over exponent and mantissa width.
- 3-stage pipeline with valid/ready handshake on both sides, full back-pressure, and an 8-bit status word carried alongside each result.
- Sits between operand-issue logic and the result writeback/FIFO in the FP datapath.

Parameters:
- EXP_W, 8, exponent field width in bits (bias = 2^(EXP_W-1)-1).
- MAN_W, 23, stored fraction width in bits (hidden bit not stored).
- W, EXP_W+MAN_W+1, total word width (derived, not overridable).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- in_valid  input  1  operand pair a/b/rnd valid.
- in_ready  output  1  pipeline accepts input this cycle.
- a  input  W  operand A {sign, exp, frac}.
- b  input  W  operand B.
- rnd  input  3  rounding mode, sampled with operands.
- out_valid  output  1  z/status valid.
- out_ready  input  1  downstream accepts result.
- z  output  W  product.
- status  output  8  [0] zero, [1] inf, [2] nan, [3] tiny, [4] huge, [5] inexact, [7:6] always 0.

Behaviour:
- Reset (async assert, sync release): every stage valid bit cleared; out_valid=0, z=0, status=0. in_ready is 1 once rst deasserts. Reset mid-operation discards all in-flight operations; no result for them ever appears.
- Transfer rules:
  - An input transfer occurs when in_valid && in_ready.
  - An output transfer occurs when out_valid && out_ready.
  - A stage advances when the next stage is empty or is advancing in the same cycle.
  - in_ready = !s1_valid || s1_advance; it is combinational from out_ready through the stage chain.
- Latency and throughput: 3 cycles from input transfer to out_valid with no stall; throughput 1 per cycle. Results emerge in input order with none lost or duplicated. z/status hold stable while out_valid && !out_ready.
- Stage 1:
  - sign = sa^sb.
  - Classify operands; subnormal inputs are flushed to zero.
  - Unbiased exponent sum in EXP_W+2 signed bits.
  - Full (MAN_W+1)x(MAN_W+1) significand product.
  - rnd registered with the operation.
- Stage 2:
  - Normalise: if product MSB is set, shift right 1 and exp+1.
  - Extract guard bit; sticky = OR of all lower bits.
- Stage 3: round, apply exceptions, register z/status.
  - Rounding modes, increment decided by LSB, guard, sticky, sign:
    - 000 nearest-even.
    - 001 toward zero.
    - 010 toward +inf.
    - 011 toward -inf.
    - 100 nearest-ties-away.
    - 101 away from zero.
    - 110/111 behave as 000.
  - A rounding carry-out renormalises the mantissa and increments the exponent.
- Exceptions, in priority order:
  1. NaN operand, or inf x zero: z = canonical qNaN {0, all-ones exp, 1, zeros}; nan=1.
  2. Inf operand: z = signed inf; inf=1.
  3. Zero operand: z = signed zero; zero=1.
  4. Post-round exponent >= 2^EXP_W-1: huge=1, inexact=1. Modes 001, 011 on positive results, and 010 on negative results, give signed max-normal. All other cases give signed inf with inf=1.
  5. Post-round exponent < 1: tiny=1, inexact=1. Modes 101, 010 on positive results, and 011 on negative results, give signed min-normal. All other cases give signed zero with zero=1.
  6. Otherwise: normal result; inexact = guard|sticky.
- inexact is produced in stage 3 only; it is never an external port.

Test Plan:
- Basic product: a=0x3FC00000, b=0x40000000, rnd=000, defaults -> z=0x40400000, status=0x00, out_valid exactly 3 cycles after the input transfer.
- Overflow by mode: a=b=0x7F000000. rnd=000 -> z=0x7F800000, status=0x32. rnd=001 -> z=0x7F7FFFFF, status=0x30.
- Invalid and signed zero:
  - a=0x7F800000 (inf), b=0x00000000 -> z=0x7FC00000, status=0x04.
  - a=0x80000000, b=0x3F800000 -> z=0x80000000, status=0x01.
- Underflow: a=0x00800000, b=0x3F000000. rnd=000 -> z=0x00000000, status=0x29. rnd=010 -> z=0x00800000, status=0x28.
- Back-pressure: 6 back-to-back operands (k+1.0 x 2.0, k=0..5) with out_ready=0 for 6 cycles -> in_ready falls after 3 accepted. Once out_ready=1, all 6 results 0x40000000..0x41400000 appear in order, none dropped. z is stable while stalled.
- Reset mid-flight: assert rst with 2 operations in the pipe -> out_valid=0 immediately (asynchronous). After release, no stale result appears, and a new operation completes after 3 cycles.

Source files
------------

// File: rtl/fp_mult_pipe.sv
// Three-stage pipelined floating-point multiplier with valid/ready on both sides.
// Subnormal operands are flushed to zero; results carry an 8-bit status word.
module fp_mult_pipe #(
   parameter int  EXP_W = 8,
   parameter int  MAN_W = 23,
   localparam int W     = EXP_W + MAN_W + 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic [2:0]   rnd,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] z,
   output logic [7:0]   status
);

   localparam int ES = EXP_W + 2;
   localparam int PW = 2 * MAN_W + 2;
   localparam int SW = MAN_W + 2;
   localparam logic signed [ES-1:0] BIAS    = ES'((1 << (EXP_W - 1)) - 1);
   localparam logic signed [ES-1:0] EXP_TOP = ES'((1 << EXP_W) - 1);
   localparam logic signed [ES-1:0] EXP_ONE = ES'(1);

   logic s1_valid, s2_valid, s3_valid;
   logic s1_ready, s2_ready, s3_ready;

   // Back-pressure ripples combinationally from out_ready to in_ready.
   assign s3_ready  = !s3_valid || out_ready;
   assign s2_ready  = !s2_valid || s3_ready;
   assign s1_ready  = !s1_valid || s2_ready;
   assign in_ready  = s1_ready;
   assign out_valid = s3_valid;

   logic [EXP_W-1:0] ea, eb;
   logic [MAN_W-1:0] fa, fb;
   logic             a_nan, a_inf, a_zero, b_nan, b_inf, b_zero;
   logic signed [ES-1:0] exp_sum;

   assign ea      = a[W-2 -: EXP_W];
   assign eb      = b[W-2 -: EXP_W];
   assign fa      = a[MAN_W-1:0];
   assign fb      = b[MAN_W-1:0];
   assign a_zero  = ~|ea;
   assign b_zero  = ~|eb;
   assign a_nan   = (&ea) && (|fa);
   assign b_nan   = (&eb) && (|fb);
   assign a_inf   = (&ea) && !(|fa);
   assign b_inf   = (&eb) && !(|fb);
   assign exp_sum = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS;

   logic                 s1_sign, s1_nan, s1_inf, s1_zero;
   logic signed [ES-1:0] s1_exp;
   logic [PW-1:0]        s1_prod;
   logic [2:0]           s1_rnd;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_sign  <= 1'b0;
         s1_nan   <= 1'b0;
         s1_inf   <= 1'b0;
         s1_zero  <= 1'b0;
         s1_exp   <= '0;
         s1_prod  <= '0;
         s1_rnd   <= '0;
      end else if (s1_ready) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_sign <= a[W-1] ^ b[W-1];
            s1_nan  <= a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf);
            s1_inf  <= a_inf || b_inf;
            s1_zero <= a_zero || b_zero;
            s1_exp  <= exp_sum;
            s1_prod <= PW'({1'b1, fa}) * PW'({1'b1, fb});
            s1_rnd  <= rnd;
         end
      end
   end

   logic                 norm;
   logic [MAN_W:0]       mant_n;
   logic                 guard_n, sticky_n;
   logic signed [ES-1:0] exp_n;

   // Significand product lies in [1,4); a set MSB means one extra integer bit.
   assign norm     = s1_prod[PW-1];
   assign mant_n   = norm ? s1_prod[PW-1 -: MAN_W+1] : s1_prod[PW-2 -: MAN_W+1];
   assign guard_n  = norm ? s1_prod[MAN_W] : s1_prod[MAN_W-1];
   assign sticky_n = norm ? |s1_prod[MAN_W-1:0] : |s1_prod[MAN_W-2:0];
   assign exp_n    = norm ? s1_exp + EXP_ONE : s1_exp;

   logic                 s2_sign, s2_nan, s2_inf, s2_zero, s2_guard, s2_sticky;
   logic signed [ES-1:0] s2_exp;
   logic [MAN_W:0]       s2_mant;
   logic [2:0]           s2_rnd;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s2_valid  <= 1'b0;
         s2_sign   <= 1'b0;
         s2_nan    <= 1'b0;
         s2_inf    <= 1'b0;
         s2_zero   <= 1'b0;
         s2_guard  <= 1'b0;
         s2_sticky <= 1'b0;
         s2_exp    <= '0;
         s2_mant   <= '0;
         s2_rnd    <= '0;
      end else if (s2_ready) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            s2_sign   <= s1_sign;
            s2_nan    <= s1_nan;
            s2_inf    <= s1_inf;
            s2_zero   <= s1_zero;
            s2_guard  <= guard_n;
            s2_sticky <= sticky_n;
            s2_exp    <= exp_n;
            s2_mant   <= mant_n;
            s2_rnd    <= s1_rnd;
         end
      end
   end

   logic                 inc, lost, carry, sat_max, sat_min;
   logic [SW-1:0]        mant_sum;
   logic [MAN_W-1:0]     frac_r;
   logic signed [ES-1:0] exp_r;
   logic [W-1:0]         z_next;
   logic [7:0]           status_next;

   always_comb begin
      lost = s2_guard || s2_sticky;
      inc  = 1'b0;
      case (s2_rnd)
         3'b001:  inc = 1'b0;
         3'b010:  inc = !s2_sign && lost;
         3'b011:  inc = s2_sign && lost;
         3'b100:  inc = s2_guard;
         3'b101:  inc = lost;
         default: inc = s2_guard && (s2_sticky || s2_mant[0]);
      endcase
      mant_sum = {1'b0, s2_mant} + SW'(inc);
      carry    = mant_sum[SW-1];
      frac_r   = carry ? mant_sum[MAN_W:1] : mant_sum[MAN_W-1:0];
      exp_r    = carry ? s2_exp + EXP_ONE : s2_exp;
      sat_max  = (s2_rnd == 3'b001) || (s2_rnd == 3'b011 && !s2_sign) ||
                 (s2_rnd == 3'b010 && s2_sign);
      sat_min  = (s2_rnd == 3'b101) || (s2_rnd == 3'b010 && !s2_sign) ||
                 (s2_rnd == 3'b011 && s2_sign);

      z_next      = '0;
      status_next = '0;
      if (s2_nan) begin
         z_next      = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
         status_next = 8'h04;
      end else if (s2_inf) begin
         z_next      = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
         status_next = 8'h02;
      end else if (s2_zero) begin
         z_next      = {s2_sign, {(W-1){1'b0}}};
         status_next = 8'h01;
      end else if (exp_r >= EXP_TOP) begin
         if (sat_max) begin
            z_next      = {s2_sign, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
            status_next = 8'h30;
         end else begin
            z_next      = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            status_next = 8'h32;
         end
      end else if (exp_r < EXP_ONE) begin
         if (sat_min) begin
            z_next      = {s2_sign, {(EXP_W-1){1'b0}}, 1'b1, {MAN_W{1'b0}}};
            status_next = 8'h28;
         end else begin
            z_next      = {s2_sign, {(W-1){1'b0}}};
            status_next = 8'h29;
         end
      end else begin
         z_next      = {s2_sign, exp_r[EXP_W-1:0], frac_r};
         status_next = {2'b00, lost, 5'b00000};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s3_valid <= 1'b0;
         z        <= '0;
         status   <= '0;
      end else if (s3_ready) begin
         s3_valid <= s2_valid;
         if (s2_valid) begin
            z      <= z_next;
            status <= status_next;
         end
      end
   end

endmodule

// File: tb/tb_fp_mult_pipe.sv
// Bench for fp_mult_pipe: directed corner cases, back-pressure, mid-flight reset,
// then randomized traffic scored against an integer-arithmetic reference model.
module tb_fp_mult_pipe;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready, out_valid, out_ready;
   logic [31:0] a, b, z;
   logic [2:0]  rnd;
   logic [7:0]  status;

   int checks = 0;
   int errors = 0;

   localparam int N_RAND = 300;

   logic [31:0] bp_a [6] = '{32'h3F800000, 32'h40000000, 32'h40400000,
                             32'h40800000, 32'h40A00000, 32'h40C00000};
   logic [31:0] bp_z [6] = '{32'h40000000, 32'h40800000, 32'h40C00000,
                             32'h41000000, 32'h41200000, 32'h41400000};

   always #5 clk = ~clk;

   fp_mult_pipe dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .rnd       (rnd),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .z         (z),
      .status    (status)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Exact product from integer significands; rounding decided by comparing
   // the discarded remainder against half an ulp.
   function automatic logic [39:0] ref_mul(input logic [31:0] x, input logic [31:0] y,
                                           input logic [2:0] r);
      int ex, ey, e, sh;
      longint unsigned p, kept, rem, half;
      logic sg, up, nx, ny, ix, iy, zx, zy;
      ex = int'(x[30:23]);
      ey = int'(y[30:23]);
      sg = x[31] ^ y[31];
      nx = (ex == 255) && (x[22:0] != 0);
      ny = (ey == 255) && (y[22:0] != 0);
      ix = (ex == 255) && (x[22:0] == 0);
      iy = (ey == 255) && (y[22:0] == 0);
      zx = (ex == 0);
      zy = (ey == 0);
      if (nx || ny || (ix && zy) || (zx && iy)) return {32'h7FC00000, 8'h04};
      if (ix || iy) return {sg, 31'h7F800000, 8'h02};
      if (zx || zy) return {sg, 31'h0, 8'h01};
      p    = {40'd0, 1'b1, x[22:0]} * {40'd0, 1'b1, y[22:0]};
      sh   = (p >= (64'd1 << 47)) ? 24 : 23;
      e    = ex + ey - 127 + (sh - 23);
      kept = p >> sh;
      rem  = p - (kept << sh);
      half = 64'd1 << (sh - 1);
      case (r)
         3'd1:    up = 1'b0;
         3'd2:    up = !sg && (rem != 0);
         3'd3:    up = sg && (rem != 0);
         3'd4:    up = (rem >= half);
         3'd5:    up = (rem != 0);
         default: up = (rem > half) || ((rem == half) && kept[0]);
      endcase
      kept = kept + 64'(up);
      if (kept == (64'd1 << 24)) begin
         kept = 64'd1 << 23;
         e++;
      end
      if (e >= 255) begin
         if (r == 3'd1 || (r == 3'd3 && !sg) || (r == 3'd2 && sg))
            return {sg, 8'hFE, 23'h7FFFFF, 8'h30};
         return {sg, 8'hFF, 23'h0, 8'h32};
      end
      if (e < 1) begin
         if (r == 3'd5 || (r == 3'd2 && !sg) || (r == 3'd3 && sg))
            return {sg, 8'h01, 23'h0, 8'h28};
         return {sg, 31'h0, 8'h29};
      end
      return {sg, 8'(e), kept[22:0], (rem != 0) ? 8'h20 : 8'h00};
   endfunction

   function automatic logic [31:0] rand_op();
      logic [7:0]  e;
      logic [22:0] f;
      case ($urandom_range(0, 15))
         0:       e = 8'h00;
         1:       e = 8'hFF;
         2:       e = 8'($urandom_range(0, 255));
         3:       e = 8'($urandom_range(1, 12));
         4:       e = 8'($urandom_range(240, 254));
         default: e = 8'($urandom_range(100, 154));
      endcase
      case ($urandom_range(0, 7))
         0:       f = 23'h0;
         1:       f = 23'h7FFFFF;
         2:       f = 23'($urandom_range(0, 15));
         default: f = 23'($urandom());
      endcase
      return {1'($urandom()), e, f};
   endfunction

   // Called just after a rising edge with the pipeline empty.
   task automatic op(input string tag, input logic [31:0] ta, input logic [31:0] tb2,
                     input logic [2:0] r, input logic [31:0] ez, input logic [7:0] es);
      int lat;
      out_ready = 1'b1;
      a         = ta;
      b         = tb2;
      rnd       = r;
      in_valid  = 1'b1;
      chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat      = 1;
      while (!out_valid && lat < 10) begin
         @(posedge clk); #1;
         lat++;
      end
      chk({tag, "_latency"}, 64'(lat), 64'd3);
      chk({tag, "_z"}, 64'(z), 64'(ez));
      chk({tag, "_status"}, 64'(status), 64'(es));
      @(posedge clk); #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc, got, n, stale, sent, recv, extra, cyc;
      logic took;
      logic [39:0] exp40;
      logic [39:0] sb [$];

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      a = '0; b = '0; rnd = '0;
      #12;
      chk("reset_out_valid", 64'(out_valid), 64'd0);
      chk("reset_z", 64'(z), 64'd0);
      chk("reset_status", 64'(status), 64'd0);
      @(negedge clk) rst = 1'b0;
      @(posedge clk); #1;
      chk("reset_in_ready", 64'(in_ready), 64'd1);

      op("basic",    32'h3FC00000, 32'h40000000, 3'b000, 32'h40400000, 8'h00);
      op("ovf_rne",  32'h7F000000, 32'h7F000000, 3'b000, 32'h7F800000, 8'h32);
      op("ovf_rtz",  32'h7F000000, 32'h7F000000, 3'b001, 32'h7F7FFFFF, 8'h30);
      op("inf_zero", 32'h7F800000, 32'h00000000, 3'b000, 32'h7FC00000, 8'h04);
      op("neg_zero", 32'h80000000, 32'h3F800000, 3'b000, 32'h80000000, 8'h01);
      op("unf_rne",  32'h00800000, 32'h3F000000, 3'b000, 32'h00000000, 8'h29);
      op("unf_rup",  32'h00800000, 32'h3F000000, 3'b010, 32'h00800000, 8'h28);

      // Back-pressure: six operands against a stalled output.
      out_ready = 1'b0; acc = 0; got = 0; rnd = 3'b000; b = 32'h40000000;
      for (int c = 0; c < 6; c++) begin
         in_valid = 1'b1;
         a        = bp_a[acc];
         @(negedge clk);
         if (in_valid && in_ready) acc++;
         if (c >= 3) begin
            chk("bp_stall_valid", 64'(out_valid), 64'd1);
            chk("bp_stall_z", 64'(z), 64'h40000000);
         end
         @(posedge clk); #1;
      end
      chk("bp_accepted", 64'(acc), 64'd3);
      chk("bp_in_ready_low", 64'(in_ready), 64'd0);
      out_ready = 1'b1; n = 0;
      while (got < 6 && n < 40) begin
         in_valid = (acc < 6);
         if (acc < 6) a = bp_a[acc];
         @(negedge clk);
         if (in_valid && in_ready) acc++;
         if (out_valid && out_ready) begin
            chk("bp_order", 64'(z), 64'(bp_z[got]));
            got++;
         end
         @(posedge clk); #1;
         n++;
      end
      in_valid = 1'b0;
      chk("bp_count", 64'(got), 64'd6);
      stale = 0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (out_valid) stale++;
      end
      chk("bp_no_extra", 64'(stale), 64'd0);
      @(posedge clk); #1;

      // Reset with two operations in flight.
      out_ready = 1'b0; rnd = 3'b000; b = 32'h40000000;
      in_valid = 1'b1; a = 32'h3F800000;
      @(posedge clk); #1;
      a = 32'h40400000;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      chk("rst_pre_valid", 64'(out_valid), 64'd1);
      #2 rst = 1'b1;
      #1;
      chk("rst_async_valid", 64'(out_valid), 64'd0);
      chk("rst_async_z", 64'(z), 64'd0);
      @(posedge clk);
      @(negedge clk) rst = 1'b0;
      out_ready = 1'b1;
      stale = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (out_valid) stale++;
      end
      chk("rst_no_stale", 64'(stale), 64'd0);
      @(posedge clk); #1;
      op("rst_new", 32'h40400000, 32'h40400000, 3'b000, 32'h41100000, 8'h00);

      // Randomized traffic with random stalls on both sides.
      sent = 0; recv = 0; extra = 0; cyc = 0; in_valid = 1'b0;
      while ((sent < N_RAND || sb.size() != 0) && cyc < 20000) begin
         @(negedge clk);
         took = in_valid && in_ready;
         if (took) begin
            sb.push_back(ref_mul(a, b, rnd));
            sent++;
         end
         if (out_valid && out_ready) begin
            if (sb.size() == 0) extra++;
            else begin
               exp40 = sb.pop_front();
               chk("rand_result", 64'({z, status}), 64'(exp40));
               recv++;
            end
         end
         @(posedge clk); #1;
         cyc++;
         out_ready = ($urandom_range(0, 3) != 0);
         if (took || !in_valid) begin
            if (sent < N_RAND && $urandom_range(0, 3) != 0) begin
               in_valid = 1'b1;
               a        = rand_op();
               b        = rand_op();
               rnd      = 3'($urandom_range(0, 7));
            end else begin
               in_valid = 1'b0;
            end
         end
      end
      chk("rand_received", 64'(recv), 64'(N_RAND));
      chk("rand_extra", 64'(extra), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
